// File: rtl/clipper_timebase_pkg.sv
// Shared time-of-day types and constants for the Clipper timebase and
// its timestamp consumers.
package clipper_timebase_pkg;

  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;
  localparam logic [31:0] NS_MAX     = NS_PER_SEC - 32'd1;

  typedef struct packed {
    logic [31:0] sec;
    logic [31:0] ns;
  } tod_t;

  function automatic logic ns_out_of_range(input logic [31:0] ns);
    return (ns >= NS_PER_SEC);
  endfunction

  // Forced values keep their seconds; an illegal ns field saturates.
  function automatic tod_t clamp_tod(input tod_t t);
    tod_t r;
    r = t;
    if (ns_out_of_range(t.ns)) begin
      r.ns = NS_MAX;
    end else begin
      r.ns = t.ns;
    end
    return r;
  endfunction

endpackage

// File: rtl/clipper_timebase_if.sv
// Control and timestamp bundle between the control-pin block (master)
// and the timebase (slave).
interface clipper_timebase_if #(
  parameter int FRAC_W = 16
);
  logic [7:0]        inc_ns_i;
  logic [FRAC_W-1:0] inc_frac_i;
  logic              inc_load_i;
  logic              timebase_force;
  logic [63:0]       timebase_time;
  logic              timebase_accelerate;
  logic              freeze_i;
  logic [63:0]       time_o;
  logic              pps_o;
  logic              force_err_o;
  logic              frozen_o;

  modport master (
    output inc_ns_i, inc_frac_i, inc_load_i,
    output timebase_force, timebase_time, timebase_accelerate, freeze_i,
    input  time_o, pps_o, force_err_o, frozen_o
  );

  modport slave (
    input  inc_ns_i, inc_frac_i, inc_load_i,
    input  timebase_force, timebase_time, timebase_accelerate, freeze_i,
    output time_o, pps_o, force_err_o, frozen_o
  );
endinterface

// File: rtl/clipper_tb_ns_adder.sv
// Adds a nanosecond step to a time-of-day value, folding at most one
// second into the seconds field and flagging that rollover.
module clipper_tb_ns_adder
  import clipper_timebase_pkg::*;
(
  input  tod_t        cur,
  input  logic [31:0] step,
  output tod_t        nxt,
  output logic        roll
);

  logic [31:0] ns_sum_s;

  // Single compare-subtract: the step is bounded below one second.
  always_comb begin
    ns_sum_s = cur.ns + step;
    nxt      = cur;
    roll     = 1'b0;
    if (ns_sum_s >= NS_PER_SEC) begin
      nxt.ns  = ns_sum_s - NS_PER_SEC;
      nxt.sec = cur.sec + 32'd1;
      roll    = 1'b1;
    end else begin
      nxt.ns  = ns_sum_s;
      nxt.sec = cur.sec;
      roll    = 1'b0;
    end
  end

endmodule

// File: rtl/clipper_timebase.sv
// Free-running {sec, ns} time-of-day counter with fractional-ns
// accumulator, force/freeze/accelerate controls and a PPS strobe.
module clipper_timebase
  import clipper_timebase_pkg::*;
#(
  parameter int unsigned NS_INC_DEF   = 8,
  parameter int unsigned FRAC_W       = 16,
  parameter int unsigned FRAC_INC_DEF = 0,
  parameter int unsigned ACCEL_SHIFT  = 10
) (
  input logic               clk,
  input logic               rst,
  clipper_timebase_if.slave tbus
);

  tod_t              tod_r;
  logic [FRAC_W-1:0] frac_acc_r;
  logic [7:0]        inc_ns_r;
  logic [FRAC_W-1:0] inc_frac_r;
  logic              pps_r;
  logic              force_err_r;
  logic              frozen_r;

  logic [FRAC_W:0]   frac_sum_s;
  logic              carry_s;
  logic [31:0]       step_base_s;
  logic [31:0]       step_s;
  tod_t              count_tod_s;
  logic              roll_s;
  tod_t              force_tod_s;
  logic              force_ovf_s;

  // Fraction carry feeds the integer step; acceleration scales only the
  // integer step so the fractional rate is untouched.
  always_comb begin
    frac_sum_s  = {1'b0, frac_acc_r} + {1'b0, inc_frac_r};
    carry_s     = frac_sum_s[FRAC_W];
    step_base_s = {24'd0, inc_ns_r} + {31'd0, carry_s};
    if (tbus.timebase_accelerate) begin
      step_s = step_base_s << ACCEL_SHIFT;
    end else begin
      step_s = step_base_s;
    end
  end

  // Force value with the ns field saturated to the last legal nanosecond.
  always_comb begin
    force_ovf_s = ns_out_of_range(tbus.timebase_time[31:0]);
    force_tod_s = clamp_tod(tod_t'(tbus.timebase_time));
  end

  clipper_tb_ns_adder u_ns_adder (
    .cur  (tod_r),
    .step (step_s),
    .nxt  (count_tod_s),
    .roll (roll_s)
  );

  // Time state: force beats freeze beats normal counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tod_r       <= '0;
      frac_acc_r  <= '0;
      pps_r       <= 1'b0;
      force_err_r <= 1'b0;
    end else if (tbus.timebase_force) begin
      tod_r       <= force_tod_s;
      frac_acc_r  <= '0;
      pps_r       <= 1'b0;
      force_err_r <= force_ovf_s;
    end else if (tbus.freeze_i) begin
      tod_r       <= tod_r;
      frac_acc_r  <= frac_acc_r;
      pps_r       <= 1'b0;
      force_err_r <= 1'b0;
    end else begin
      tod_r       <= count_tod_s;
      frac_acc_r  <= frac_sum_s[FRAC_W-1:0];
      pps_r       <= roll_s;
      force_err_r <= 1'b0;
    end
  end

  // Increment registers load on request in every mode, including freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_ns_r   <= 8'(NS_INC_DEF);
      inc_frac_r <= FRAC_W'(FRAC_INC_DEF);
    end else if (tbus.inc_load_i) begin
      inc_ns_r   <= tbus.inc_ns_i;
      inc_frac_r <= tbus.inc_frac_i;
    end else begin
      inc_ns_r   <= inc_ns_r;
      inc_frac_r <= inc_frac_r;
    end
  end

  // Registered freeze indication for downstream consumers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen_r <= 1'b0;
    end else begin
      frozen_r <= tbus.freeze_i;
    end
  end

  assign tbus.time_o      = 64'(tod_r);
  assign tbus.pps_o       = pps_r;
  assign tbus.force_err_o = force_err_r;
  assign tbus.frozen_o    = frozen_r;

endmodule

// File: tb/tb_clipper_timebase.sv
// Directed bench for clipper_timebase: a total-nanosecond model checked
// every cycle, plus hand-computed checkpoints.
module tb_clipper_timebase;

  localparam longint unsigned NSEC = 64'd1_000_000_000;
  localparam longint unsigned WRAP = 64'd4294967296 * 64'd1_000_000_000;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  bit   check_en;

  clipper_timebase_if #(.FRAC_W(16)) bus ();

  clipper_timebase dut (
    .clk  (clk),
    .rst  (rst),
    .tbus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: time as a single count of nanoseconds since {0,0}
  longint unsigned m_total;
  int unsigned     m_frac;
  int unsigned     m_inc_ns;
  int unsigned     m_inc_frac;
  bit              m_pps;
  bit              m_err;
  bit              m_frozen;

  function automatic longint unsigned advance(input longint unsigned total,
                                              input int unsigned inc_ns,
                                              input int unsigned carry,
                                              input bit accel);
    longint unsigned t;
    t = total + longint'(inc_ns + carry) * (accel ? 64'd1024 : 64'd1);
    if (t >= WRAP) t = t - WRAP;
    return t;
  endfunction

  function automatic longint unsigned forced_total(input logic [63:0] tt);
    longint unsigned ns;
    ns = longint'(tt[31:0]);
    if (ns >= NSEC) ns = NSEC - 64'd1;
    return longint'(tt[63:32]) * NSEC + ns;
  endfunction

  function automatic logic [63:0] to_tod(input longint unsigned total);
    logic [31:0] s;
    logic [31:0] n;
    s = 32'(total / NSEC);
    n = 32'(total % NSEC);
    return {s, n};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_total    <= 64'd0;
      m_frac     <= 0;
      m_inc_ns   <= 8;
      m_inc_frac <= 0;
      m_pps      <= 1'b0;
      m_err      <= 1'b0;
      m_frozen   <= 1'b0;
    end else begin
      if (bus.timebase_force) begin
        m_total <= forced_total(bus.timebase_time);
        m_frac  <= 0;
        m_pps   <= 1'b0;
        m_err   <= (bus.timebase_time[31:0] >= 32'd1_000_000_000);
      end else if (bus.freeze_i) begin
        m_pps <= 1'b0;
        m_err <= 1'b0;
      end else begin
        m_total <= advance(m_total, m_inc_ns, (m_frac + m_inc_frac) >> 16, bus.timebase_accelerate);
        m_frac  <= (m_frac + m_inc_frac) & 32'hFFFF;
        m_pps   <= (advance(m_total, m_inc_ns, (m_frac + m_inc_frac) >> 16,
                            bus.timebase_accelerate) / NSEC) != (m_total / NSEC);
        m_err   <= 1'b0;
      end
      if (bus.inc_load_i) begin
        m_inc_ns   <= int'(bus.inc_ns_i);
        m_inc_frac <= int'(bus.inc_frac_i);
      end
      m_frozen <= bus.freeze_i;
    end
  end

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got sec=%0d ns=%0d, want sec=%0d ns=%0d at %0t",
               name, act[63:32], act[31:0], exp[63:32], exp[31:0], $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk64("model time_o", bus.time_o, to_tod(m_total));
      chk1("model pps_o", bus.pps_o, m_pps);
      chk1("model force_err_o", bus.force_err_o, m_err);
      chk1("model frozen_o", bus.frozen_o, m_frozen);
    end
  end

  task automatic do_force(input logic [63:0] t);
    bus.timebase_force = 1'b1;
    bus.timebase_time  = t;
    @(negedge clk);
    bus.timebase_force = 1'b0;
  endtask

  task automatic do_force_load(input logic [63:0] t, input logic [7:0] ns, input logic [15:0] fr);
    bus.inc_load_i = 1'b1;
    bus.inc_ns_i   = ns;
    bus.inc_frac_i = fr;
    do_force(t);
    bus.inc_load_i = 1'b0;
  endtask

  logic [31:0] seq_ns [4];

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    check_en = 1'b0;
    rst      = 1'b1;
    bus.inc_ns_i            = 8'd0;
    bus.inc_frac_i          = 16'd0;
    bus.inc_load_i          = 1'b0;
    bus.timebase_force      = 1'b0;
    bus.timebase_time       = 64'd0;
    bus.timebase_accelerate = 1'b0;
    bus.freeze_i            = 1'b0;
    seq_ns[0] = 32'd6;
    seq_ns[1] = 32'd13;
    seq_ns[2] = 32'd19;
    seq_ns[3] = 32'd26;

    repeat (2) @(negedge clk);
    chk64("reset time_o", bus.time_o, 64'd0);
    chk1("reset pps_o", bus.pps_o, 1'b0);
    chk1("reset force_err_o", bus.force_err_o, 1'b0);
    chk1("reset frozen_o", bus.frozen_o, 1'b0);
    rst      = 1'b0;
    check_en = 1'b1;

    // Free run with defaults
    repeat (250) @(negedge clk);
    chk64("free run 250", bus.time_o, {32'd0, 32'd2000});

    // Rollover into second 6
    do_force({32'd5, 32'd999_999_992});
    chk64("force load", bus.time_o, {32'd5, 32'd999_999_992});
    chk1("force no pps", bus.pps_o, 1'b0);
    @(negedge clk);
    chk64("rollover", bus.time_o, {32'd6, 32'd0});
    chk1("rollover pps", bus.pps_o, 1'b1);
    @(negedge clk);
    chk1("pps one cycle", bus.pps_o, 1'b0);

    // Illegal ns field saturates
    do_force({32'd5, 32'd1_200_000_000});
    chk64("force clamp", bus.time_o, {32'd5, 32'd999_999_999});
    chk1("force_err pulse", bus.force_err_o, 1'b1);
    @(negedge clk);
    chk1("force_err one cycle", bus.force_err_o, 1'b0);
    chk64("after clamp", bus.time_o, {32'd6, 32'd7});

    // 6.5 ns increment
    do_force_load(64'd0, 8'd6, 16'h8000);
    chk64("force zero", bus.time_o, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk64("frac seq", bus.time_o, {32'd0, seq_ns[i]});
    end

    // Accelerate for 10 cycles at 8 ns
    do_force_load(64'd0, 8'd8, 16'd0);
    bus.timebase_accelerate = 1'b1;
    repeat (10) @(negedge clk);
    bus.timebase_accelerate = 1'b0;
    chk64("accel 10", bus.time_o, {32'd0, 32'd81920});
    @(negedge clk);
    chk64("accel off", bus.time_o, {32'd0, 32'd81928});
    @(negedge clk);

    // Freeze, force while frozen, release
    bus.freeze_i = 1'b1;
    repeat (100) @(negedge clk);
    chk64("freeze hold", bus.time_o, {32'd0, 32'd81936});
    chk1("frozen_o", bus.frozen_o, 1'b1);
    do_force({32'd1, 32'd7});
    chk64("force in freeze", bus.time_o, {32'd1, 32'd7});
    repeat (5) @(negedge clk);
    chk64("forced hold", bus.time_o, {32'd1, 32'd7});
    bus.freeze_i = 1'b0;
    @(negedge clk);
    chk64("unfreeze", bus.time_o, {32'd1, 32'd15});
    chk1("frozen_o clear", bus.frozen_o, 1'b0);

    // Zero increment stalls the clock
    do_force_load({32'd2, 32'd100}, 8'd0, 16'd0);
    repeat (3) @(negedge clk);
    chk64("zero inc stall", bus.time_o, {32'd2, 32'd100});
    do_force_load({32'hFFFF_FFFF, 32'd999_999_996}, 8'd8, 16'd0);

    // Seconds wrap
    @(negedge clk);
    chk64("sec wrap", bus.time_o, {32'd0, 32'd4});
    chk1("sec wrap pps", bus.pps_o, 1'b1);

    // Async reset mid-cycle restores default increment
    bus.inc_load_i = 1'b1;
    bus.inc_ns_i   = 8'd3;
    @(negedge clk);
    bus.inc_load_i = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk64("async reset", bus.time_o, 64'd0);
    chk1("async reset pps", bus.pps_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk64("restart default", bus.time_o, {32'd0, 32'd8});
    @(negedge clk);
    chk64("restart default 2", bus.time_o, {32'd0, 32'd16});

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clipper_timebase.md
Name: clipper_timebase

Overview:
- Free-running 64-bit PTP-style time-of-day counter for the Clipper datapath.
- Format: seconds in [63:32], nanoseconds in [31:0].
- Sits directly downstream of the control-pin block: consumes the timebase_force/timebase_accelerate/timebase_time and freeze controls, and feeds timestamp consumers (flowmeter, PTP stamping).
- Adds a fractional-nanosecond accumulator and a PPS strobe.

Parameters:
- NS_INC_DEF, 8, default integer ns added per clk (125 MHz).
- FRAC_W, 16, width of fractional-ns accumulator.
- FRAC_INC_DEF, 0, default fractional increment, units 2^-FRAC_W ns.
- ACCEL_SHIFT, 10, left shift applied to the increment while accelerate is high. Constraint: (NS_INC max+1) << ACCEL_SHIFT < 1e9.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- inc_ns_i  in  8  runtime integer ns increment
- inc_frac_i  in  FRAC_W  runtime fractional increment
- inc_load_i  in  1  pulse; latch inc_ns_i/inc_frac_i
- timebase_force  in  1  pulse; load timebase_time
- timebase_time  in  64  time to load {sec,ns}
- timebase_accelerate  in  1  level; shift the increment by ACCEL_SHIFT
- freeze_i  in  1  level; hold the time value
- time_o  out  64  current time {sec[31:0], ns[31:0]}
- pps_o  out  1  one-cycle pulse on each seconds increment
- force_err_o  out  1  one-cycle pulse when the forced ns field was ≥1e9
- frozen_o  out  1  registered copy of freeze_i

Behaviour:
- Reset: time_o=0, frac_acc=0, pps_o=0, force_err_o=0, frozen_o=0, inc regs = NS_INC_DEF/FRAC_INC_DEF. Reset is async assert; deassertion is assumed synchronised upstream.
- All outputs are registered. A control sampled on clk edge N is visible on time_o after edge N.
- Increment registers:
  - inc_load_i=1 latches the new values at the edge.
  - The new increment is first used on the following cycle.
- Per-cycle priority: force > freeze > normal count.
- Force:
  - time_o ← timebase_time; frac_acc ← 0.
  - If timebase_time[31:0] ≥ 1e9: ns is clamped to 999_999_999 and force_err_o pulses.
  - pps_o=0 on a force cycle.
  - A force while freeze is high still loads, and the value then holds.
- Freeze: time_o, frac_acc and the increment registers all hold; inc_load_i is still honoured.
- Normal count:
  - {carry, frac_acc} = frac_acc + inc_frac. Fraction wraps mod 2^FRAC_W; carry is 1 bit.
  - step = (inc_ns + carry) << (accelerate ? ACCEL_SHIFT : 0).
  - The accelerate shift applies to the integer step only. The fractional accumulator continues unshifted.
  - ns_sum = ns + step, computed 32-bit with no overflow given the constraint.
  - If ns_sum ≥ 1e9: ns ← ns_sum − 1e9, sec ← sec+1, pps_o=1 for that cycle. Otherwise ns ← ns_sum.
  - At most one second rollover per cycle, guaranteed by the constraint.
- Seconds wrap: 0xFFFF_FFFF + 1 → 0, with no flag; pps_o still pulses.
- inc_ns=0 with inc_frac=0 is legal: time stalls, no error.
- Simultaneous force and rollover: force wins, no pps.
- Reset mid-count: immediate async clear, and counting restarts from 0 with the default increments.

Decomposition:
- clipper_pkg gains:
  - NS_PER_SEC = 32'd1_000_000_000
  - NS_MAX = NS_PER_SEC−1
  - typedef struct packed {logic[31:0] sec; logic[31:0] ns;} tod_t
- time_o is a tod_t cast.
- One sub-module, clipper_tb_ns_adder:
  - combinational/registered ns+step compare-subtract with sec carry and pps.
  - Reused by the future one-step PTP correction block.
- Fractional accumulator and control priority stay in the top.

Test Plan:
- Reset release, defaults, 250 cycles free-run → time_o = {0, 2000}, pps_o never high.
- Force {5, 999_999_992}, then run 1 cycle → time_o = {6, 0} and pps_o=1 exactly on that cycle. Force {5, 1_200_000_000} → ns=999_999_999 and force_err_o=1 for one cycle.
- inc_load ns=6, frac=0x8000 (6.5 ns), run 4 cycles from 0 → ns sequence 6, 13, 19, 26.
- Accelerate high for 10 cycles at inc 8 → ns advances 81920; then drop accelerate → +8/cycle.
- Freeze high 100 cycles → time_o constant and frozen_o=1; force during freeze loads {1, 7} and holds; release → counting resumes from {1, 7}.
- Force {0xFFFF_FFFF, 999_999_996}, 1 cycle → {0, 4} with pps_o=1. Async rst asserted mid-cycle → time_o=0 before the next clk edge.
